// File: rtl/gpr_writeback_queue.sv
// Purpose : in-order queue of register-file writes, drained one per cycle, with read-side forwarding.
// Latency : a request accepted at edge N reaches the write port in cycle N+1 at the earliest.
// Backpres: request_ready drops when full (a pop does not free space that cycle); write_stall holds the head.
//
// Ports:
//   system_clock / system_reset         rising-edge clock, synchronous active-high reset
//   request_valid/ready/address/data    write requests from writeback sources (address 0 is dropped)
//   write_stall                         register file write port busy this cycle
//   write_enable/address/data           register file write port
//   lookup_address_N -> lookup_hit_N / lookup_data_N   forwarding of still-queued data (youngest match)
//   occupancy                           number of valid entries
module gpr_writeback_queue #(
    parameter int REGISTER_SIZE  = 32,
    parameter int REGISTER_COUNT = 32,
    parameter int ADDRESS_SIZE   = $clog2(REGISTER_COUNT),
    parameter int DEPTH          = 4
) (
    input  logic                       system_clock,
    input  logic                       system_reset,
    input  logic                       request_valid,
    output logic                       request_ready,
    input  logic [ADDRESS_SIZE-1:0]    request_address,
    input  logic [REGISTER_SIZE-1:0]   request_data,
    input  logic                       write_stall,
    output logic                       write_enable,
    output logic [ADDRESS_SIZE-1:0]    write_address,
    output logic [REGISTER_SIZE-1:0]   write_data,
    input  logic [ADDRESS_SIZE-1:0]    lookup_address_1,
    input  logic [ADDRESS_SIZE-1:0]    lookup_address_2,
    output logic                       lookup_hit_1,
    output logic                       lookup_hit_2,
    output logic [REGISTER_SIZE-1:0]   lookup_data_1,
    output logic [REGISTER_SIZE-1:0]   lookup_data_2,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0]  address;
        logic [REGISTER_SIZE-1:0] data;
    } entry_t;

    entry_t            storage [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic              not_empty;
    logic [PTR_W-1:0]  idx;

    assign not_empty     = (count != '0);
    assign request_ready = (count != CNT_W'(DEPTH));
    // Writes to r0 complete the handshake but are never queued.
    assign push          = request_valid && request_ready && (request_address != '0);
    assign pop           = write_enable;

    assign write_enable  = not_empty && !write_stall;
    assign write_address = not_empty ? storage[head].address : '0;
    assign write_data    = not_empty ? storage[head].data    : '0;
    assign occupancy     = count;

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents need no reset; only the pointers define validity.
    always_ff @(posedge system_clock) begin
        if (push) begin
            storage[tail] <= '{address: request_address, data: request_data};
        end
    end

    // Walk valid entries from oldest (head) to youngest so the last match wins,
    // independent of where the buffer has wrapped. The head is included even
    // while it is being popped, since the register file only updates at the edge.
    always_comb begin
        lookup_hit_1  = 1'b0;
        lookup_hit_2  = 1'b0;
        lookup_data_1 = '0;
        lookup_data_2 = '0;
        idx           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((lookup_address_1 != '0) && (storage[idx].address == lookup_address_1)) begin
                    lookup_hit_1  = 1'b1;
                    lookup_data_1 = storage[idx].data;
                end
                if ((lookup_address_2 != '0) && (storage[idx].address == lookup_address_2)) begin
                    lookup_hit_2  = 1'b1;
                    lookup_data_2 = storage[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Purpose : directed checks of gpr_writeback_queue (DEPTH=4) with hand-computed expectations.
// Latency : inputs change 1 time unit after the rising edge, outputs are checked 2 units later.
// Backpres: exercises full queue, write_stall hold, r0 drop, reset flush and pointer wrap.
module tb_gpr_writeback_queue;

    localparam int RS = 32;
    localparam int AS = 5;
    localparam int DP = 4;

    logic          system_clock = 1'b0;
    logic          system_reset;
    logic          request_valid;
    logic          request_ready;
    logic [AS-1:0] request_address;
    logic [RS-1:0] request_data;
    logic          write_stall;
    logic          write_enable;
    logic [AS-1:0] write_address;
    logic [RS-1:0] write_data;
    logic [AS-1:0] lookup_address_1;
    logic [AS-1:0] lookup_address_2;
    logic          lookup_hit_1;
    logic          lookup_hit_2;
    logic [RS-1:0] lookup_data_1;
    logic [RS-1:0] lookup_data_2;
    logic [2:0]    occupancy;

    int total = 0;
    int bad   = 0;

    gpr_writeback_queue #(
        .REGISTER_SIZE(RS), .REGISTER_COUNT(32), .ADDRESS_SIZE(AS), .DEPTH(DP)
    ) dut (
        .system_clock(system_clock),         .system_reset(system_reset),
        .request_valid(request_valid),       .request_ready(request_ready),
        .request_address(request_address),   .request_data(request_data),
        .write_stall(write_stall),           .write_enable(write_enable),
        .write_address(write_address),       .write_data(write_data),
        .lookup_address_1(lookup_address_1), .lookup_address_2(lookup_address_2),
        .lookup_hit_1(lookup_hit_1),         .lookup_hit_2(lookup_hit_2),
        .lookup_data_1(lookup_data_1),       .lookup_data_2(lookup_data_2),
        .occupancy(occupancy)
    );

    always #5 system_clock = ~system_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push_req(input logic [AS-1:0] a, input logic [RS-1:0] d);
        request_valid   = 1'b1;
        request_address = a;
        request_data    = d;
    endtask

    initial begin
        system_reset     = 1'b1;
        request_valid    = 1'b0;
        request_address  = '0;
        request_data     = '0;
        write_stall      = 1'b0;
        lookup_address_1 = 5'd5;
        lookup_address_2 = '0;
        tick();
        tick();
        system_reset = 1'b0;
        settle();

        // Reset state
        chk("rst_we",    write_enable,  0);
        chk("rst_waddr", write_address, 0);
        chk("rst_wdata", write_data,    0);
        chk("rst_ready", request_ready, 1);
        chk("rst_occ",   occupancy,     0);
        chk("rst_hit1",  lookup_hit_1,  0);
        chk("rst_data1", lookup_data_1, 0);
        chk("rst_hit2",  lookup_hit_2,  0);

        // Single write: no same-cycle bypass, appears next cycle, then drains
        tick();
        push_req(5'd3, 32'hAAAA0001);
        lookup_address_1 = 5'd3;
        settle();
        chk("single_ready",     request_ready, 1);
        chk("single_no_bypass", write_enable,  0);
        chk("single_no_fwd",    lookup_hit_1,  0);
        tick();
        request_valid = 1'b0;
        settle();
        chk("single_we",    write_enable,  1);
        chk("single_waddr", write_address, 3);
        chk("single_wdata", write_data,    32'hAAAA0001);
        chk("single_occ1",  occupancy,     1);
        chk("single_fwd",   lookup_hit_1,  1);
        chk("single_fwdd",  lookup_data_1, 32'hAAAA0001);
        tick();
        settle();
        chk("single_occ0",  occupancy,     0);
        chk("single_we0",   write_enable,  0);

        // Fill under stall, fifth request refused, drain in order
        write_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            push_req(AS'(k), 32'h11 * k);
        end
        tick();
        push_req(5'd5, 32'h55);
        lookup_address_1 = 5'd2;
        settle();
        chk("full_occ",    occupancy,     4);
        chk("full_ready",  request_ready, 0);
        chk("full_we",     write_enable,  0);
        chk("full_waddr",  write_address, 1);
        chk("full_fwd2",   lookup_data_1, 32'h22);
        tick();
        request_valid = 1'b0;
        settle();
        chk("full_occ_hold", occupancy, 4);
        tick();
        write_stall = 1'b0;
        settle();
        chk("full_no_passthru", request_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_we",    write_enable,  1);
            chk("drain_waddr", write_address, k);
            chk("drain_wdata", write_data,    32'h11 * k);
            tick();
            settle();
        end
        chk("drain_ready", request_ready, 1);
        chk("drain_occ",   occupancy,     0);
        chk("drain_we0",   write_enable,  0);

        // Same-address entries: lookup returns youngest, drain oldest first
        write_stall = 1'b1;
        tick();
        push_req(5'd7, 32'h10);
        tick();
        push_req(5'd7, 32'h20);
        tick();
        request_valid    = 1'b0;
        lookup_address_1 = 5'd7;
        lookup_address_2 = 5'd3;
        settle();
        chk("dup_hit1",  lookup_hit_1,  1);
        chk("dup_data1", lookup_data_1, 32'h20);
        chk("dup_hit2",  lookup_hit_2,  0);
        chk("dup_data2", lookup_data_2, 0);
        lookup_address_2 = 5'd7;
        settle();
        chk("dup_p2_data", lookup_data_2, 32'h20);
        tick();
        write_stall = 1'b0;
        settle();
        chk("dup_first",  write_data, 32'h10);
        tick();
        settle();
        chk("dup_second", write_data, 32'h20);
        chk("dup_fwd_after_pop", lookup_data_1, 32'h20);
        tick();
        settle();
        chk("dup_occ0", occupancy, 0);

        // Write to r0 handshakes but is dropped
        push_req(5'd0, 32'hDEAD);
        lookup_address_1 = 5'd0;
        settle();
        chk("r0_ready", request_ready, 1);
        tick();
        request_valid = 1'b0;
        settle();
        chk("r0_occ",  occupancy,    0);
        chk("r0_we",   write_enable, 0);
        chk("r0_hit",  lookup_hit_1, 0);
        tick();
        settle();
        chk("r0_we_later", write_enable, 0);

        // Reset flushes queued entries, wins over a concurrent push
        write_stall = 1'b1;
        tick();
        push_req(5'd9, 32'h91);
        tick();
        push_req(5'd10, 32'hA2);
        tick();
        push_req(5'd11, 32'hB3);
        tick();
        settle();
        chk("pre_rst_occ", occupancy, 3);
        push_req(5'd12, 32'hC4);
        system_reset = 1'b1;
        tick();
        system_reset  = 1'b0;
        request_valid = 1'b0;
        write_stall   = 1'b0;
        lookup_address_1 = 5'd9;
        settle();
        chk("rst_mid_occ", occupancy,    0);
        chk("rst_mid_we",  write_enable, 0);
        chk("rst_mid_hit", lookup_hit_1, 0);
        tick();
        settle();
        chk("rst_mid_we2", write_enable, 0);

        // Continuous push/pop through more than two wraps
        for (int j = 0; j < 9; j++) begin
            push_req(AS'(j + 1), 32'h100 + j);
            settle();
            if (j == 0) begin
                chk("wrap_first_idle", write_enable, 0);
            end else begin
                chk("wrap_we",    write_enable,  1);
                chk("wrap_waddr", write_address, j);
                chk("wrap_wdata", write_data,    32'h100 + j - 1);
                chk("wrap_occ",   occupancy,     1);
            end
            tick();
        end
        request_valid = 1'b0;
        settle();
        chk("wrap_last", write_data, 32'h108);
        tick();
        settle();
        chk("wrap_occ0", occupancy, 0);

        // Age priority across the physical wrap point (head is now at index 1)
        write_stall = 1'b1;
        push_req(5'd5, 32'h1);
        tick();
        push_req(5'd6, 32'h2);
        tick();
        push_req(5'd7, 32'h3);
        tick();
        push_req(5'd5, 32'h4);
        tick();
        request_valid    = 1'b0;
        lookup_address_1 = 5'd5;
        lookup_address_2 = 5'd6;
        settle();
        chk("age_hit",   lookup_hit_1,  1);
        chk("age_data",  lookup_data_1, 32'h4);
        chk("age_data2", lookup_data_2, 32'h2);
        write_stall = 1'b0;
        settle();
        chk("age_drain0", write_data, 32'h1);
        tick();
        tick();
        tick();
        settle();
        chk("age_drain3",  write_data,    32'h4);
        chk("age_drain3a", write_address, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
